// File: rtl/fp_pkg.sv
// fp_pkg: shared types and constants for the pipelined FP multiplier.
// Holds the default 1/7/16 packed format, its widths and bias, and the
// bit positions inside the 3-bit {overflow, underflow, zero} flag vector.
package fp_pkg;

  localparam int DEF_EXP_W  = 7;
  localparam int DEF_MANT_W = 16;
  localparam int DEF_BIAS   = 2**(DEF_EXP_W-1) - 1;

  // Flag vector bit positions
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_OVF  = 2;

  // Default packed operand/result layout {sign, exp, mant}
  typedef struct packed {
    logic        sign;
    logic [6:0]  exp;
    logic [15:0] mant;
  } fp24;

endpackage

// File: rtl/fp_round_norm.sv
// fp_round_norm: combinational normalise / round / range-check / pack.
// Takes the raw significand product (value in [1,4)) and the unbiased-free
// exponent sum exp_a+exp_b. Build option FP_MULT_RNE_EN selects
// round-to-nearest-even; without it the discarded bits are truncated.
module fp_round_norm
  import fp_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int MANT_W = DEF_MANT_W,
  parameter int BIAS   = 2**(EXP_W-1) - 1
) (
  input  logic                  i_sign,
  input  logic                  i_zero,
  input  logic [EXP_W+1:0]      i_exp_sum,
  input  logic [2*MANT_W+1:0]   i_sig_prod,
  output logic [EXP_W+MANT_W:0] o_prod,
  output logic [2:0]            o_flags
);

  localparam int PW = 2*MANT_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS_E  = EW'(BIAS);
  localparam logic [EW-1:0] EXP_MAX = EW'((2**EXP_W) - 1);

  logic              w_norm_carry;
  logic [PW-2:0]     w_sig_n;
  logic [MANT_W-1:0] w_mant_t;
  logic              w_guard;
  logic              w_sticky;
  logic              w_round_inc;
  logic [MANT_W:0]   w_mant_r;
  logic              w_round_carry;
  logic [EW-1:0]     w_exp_tot;
  logic [EW-1:0]     w_exp_unb;

  // A product >= 2.0 has its MSB set: take it as-is and bump the exponent;
  // otherwise shift left so the hidden one always sits just above w_sig_n.
  assign w_norm_carry = i_sig_prod[PW-1];
  assign w_sig_n      = w_norm_carry ? i_sig_prod[PW-2:0]
                                     : {i_sig_prod[PW-3:0], 1'b0};

  assign w_mant_t = w_sig_n[2*MANT_W -: MANT_W];
  assign w_guard  = w_sig_n[MANT_W];
  assign w_sticky = |w_sig_n[MANT_W-1:0];

`ifdef FP_MULT_RNE_EN
  // Round up above half, and on an exact half only when the mantissa is odd
  assign w_round_inc = w_guard & (w_sticky | w_mant_t[0]);
`else
  // Truncation ignores the discarded bits
  logic w_unused_round;
  assign w_unused_round = w_guard ^ w_sticky;
  assign w_round_inc    = 1'b0;
`endif

  // A carry out of the rounded mantissa leaves the low bits zero (1.0 x 2)
  assign w_mant_r      = {1'b0, w_mant_t} + {{MANT_W{1'b0}}, w_round_inc};
  assign w_round_carry = w_mant_r[MANT_W];

  // EW bits hold 2*(2**EXP_W-1)+2 without wrapping
  assign w_exp_tot = i_exp_sum
                   + {{(EW-1){1'b0}}, w_norm_carry}
                   + {{(EW-1){1'b0}}, w_round_carry};
  assign w_exp_unb = w_exp_tot - BIAS_E;

  // Zero operands win over range checks; range checks use the rounded exponent
  always_comb begin
    o_prod  = '0;
    o_flags = '0;
    if (i_zero) begin
      o_flags[FLAG_ZERO] = 1'b1;
    end else if (w_exp_tot < BIAS_E) begin
      o_flags[FLAG_UNF] = 1'b1;
    end else if (w_exp_unb > EXP_MAX) begin
      o_flags[FLAG_OVF] = 1'b1;
      o_prod = {i_sign, {EXP_W{1'b1}}, {MANT_W{1'b1}}};
    end else begin
      o_prod = {i_sign, w_exp_unb[EXP_W-1:0], w_mant_r[MANT_W-1:0]};
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: three-stage pipelined floating-point multiplier.
// Operands and result are packed {sign, exp, mant} with a hidden leading one;
// exp==0 && mant==0 is zero. Stage 1 unpacks, stage 2 multiplies significands
// and sums exponents, stage 3 (fp_round_norm) normalises/rounds/packs.
// Build option: define FP_MULT_RNE_EN for round-to-nearest-even (default truncates).
//
// Handshake (valid/ready): operands transfer on a rising edge where
// in_valid && in_ready; a result transfers where out_valid && out_ready.
// Every stage advances together when adv = !out_valid || out_ready and
// in_ready equals adv, so a stalled result keeps prod/flags stable.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int MANT_W = DEF_MANT_W,
  parameter int BIAS   = 2**(EXP_W-1) - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+MANT_W:0] a,
  input  logic [EXP_W+MANT_W:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+MANT_W:0] prod,
  output logic [2:0]            flags
);

  localparam int W  = 1 + EXP_W + MANT_W;
  localparam int SW = MANT_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW = EXP_W + 2;

  logic             w_adv;
  logic             w_zero_a;
  logic             w_zero_b;

  logic             r_s1_valid;
  logic             r_s1_sign;
  logic             r_s1_zero;
  logic [EXP_W-1:0] r_s1_exp_a;
  logic [EXP_W-1:0] r_s1_exp_b;
  logic [SW-1:0]    r_s1_sig_a;
  logic [SW-1:0]    r_s1_sig_b;

  logic             r_s2_valid;
  logic             r_s2_sign;
  logic             r_s2_zero;
  logic [EW-1:0]    r_s2_exp_sum;
  logic [PW-1:0]    r_s2_sig_prod;

  logic             r_s3_valid;
  logic [W-1:0]     r_prod;
  logic [2:0]       r_flags;
  logic [W-1:0]     w_prod_n;
  logic [2:0]       w_flags_n;

  assign w_adv     = !r_s3_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_s3_valid;
  assign prod      = r_prod;
  assign flags     = r_flags;

  // Zero is exp and mant both clear, i.e. everything below the sign bit
  assign w_zero_a = (a[W-2:0] == '0);
  assign w_zero_b = (b[W-2:0] == '0);

  // Stage valids: cleared asynchronously so in-flight work is discarded on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  // Stage 1: unpack fields, attach hidden one, detect zero, form result sign
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_exp_a <= '0;
      r_s1_exp_b <= '0;
      r_s1_sig_a <= '0;
      r_s1_sig_b <= '0;
    end else if (w_adv) begin
      r_s1_sign  <= a[W-1] ^ b[W-1];
      r_s1_zero  <= w_zero_a | w_zero_b;
      r_s1_exp_a <= a[W-2 -: EXP_W];
      r_s1_exp_b <= b[W-2 -: EXP_W];
      r_s1_sig_a <= {1'b1, a[MANT_W-1:0]};
      r_s1_sig_b <= {1'b1, b[MANT_W-1:0]};
    end
  end

  // Stage 2: full-width significand multiply and widened exponent sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_sign     <= 1'b0;
      r_s2_zero     <= 1'b0;
      r_s2_exp_sum  <= '0;
      r_s2_sig_prod <= '0;
    end else if (w_adv) begin
      r_s2_sign     <= r_s1_sign;
      r_s2_zero     <= r_s1_zero;
      r_s2_exp_sum  <= EW'(r_s1_exp_a) + EW'(r_s1_exp_b);
      r_s2_sig_prod <= PW'(r_s1_sig_a) * PW'(r_s1_sig_b);
    end
  end

  fp_round_norm #(
    .EXP_W  (EXP_W),
    .MANT_W (MANT_W),
    .BIAS   (BIAS)
  ) u_round_norm (
    .i_sign     (r_s2_sign),
    .i_zero     (r_s2_zero),
    .i_exp_sum  (r_s2_exp_sum),
    .i_sig_prod (r_s2_sig_prod),
    .o_prod     (w_prod_n),
    .o_flags    (w_flags_n)
  );

  // Stage 3: register the packed result and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod  <= '0;
      r_flags <= '0;
    end else if (w_adv) begin
      r_prod  <= w_prod_n;
      r_flags <= w_flags_n;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: self-checking bench for fp_mult_pipe (default parameters).
// Reference model works on significand values with integer arithmetic.
// Honours FP_MULT_RNE_EN the same way as the design build.
module tb_fp_mult_pipe;
  import fp_pkg::*;

`ifdef FP_MULT_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] a = '0;
  logic [23:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] prod;
  logic [2:0]  flags;

  logic [26:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  fp_mult_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .flags     (flags)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: value-level multiply, normalise to [1,2), round, range check.
  // Returns {flags, prod}.
  function automatic logic [26:0] model(input fp24 x, input fp24 y);
    longint p, q, rem, half;
    int     shift, e_sum;
    logic   s;
    if ((x.exp == 0 && x.mant == 0) || (y.exp == 0 && y.mant == 0))
      return {3'b001, 24'h0};
    s = x.sign ^ y.sign;
    p = (longint'(65536) + longint'(x.mant)) * (longint'(65536) + longint'(y.mant));
    shift = (p >= (longint'(1) << 33)) ? 17 : 16;
    q     = p >> shift;
    rem   = p - (q << shift);
    half  = longint'(1) << (shift - 1);
    if (RNE && ((rem > half) || (rem == half && (q % 2) == 1))) q = q + 1;
    e_sum = int'(x.exp) + int'(y.exp) + (shift - 16);
    if (q == (longint'(1) << 17)) begin
      q = longint'(1) << 16;
      e_sum = e_sum + 1;
    end
    if (e_sum < 63) return {3'b010, 24'h0};
    if (e_sum - 63 > 127) return {3'b100, s, 7'h7f, 16'hffff};
    return {3'b000, s, 7'(e_sum - 63), q[15:0]};
  endfunction

  function automatic logic [23:0] rand_op();
    logic [23:0] v;
    v = 24'($urandom);
    if ($urandom_range(0, 1) == 1) v[22:16] = 7'($urandom_range(40, 86));
    if ($urandom_range(0, 9) == 0) v[22:0] = '0;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if ({flags, prod} !== 27'h0) begin
      failures++; $display("FAIL reset_prod_flags got=%h want=0", {flags, prod});
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [23:0] ta [10];
    logic [23:0] tb_op [10];
    logic [26:0] te [10];
    int lat;
    ta    = '{24'h3F8000, 24'hBF8000, 24'hC00000, 24'h010000, 24'h7F0000,
              24'h3F0001, 24'h3FFFFE, 24'h5FFFFE, 24'h200000, 24'h200000};
    tb_op = '{24'h3F8000, 24'h3F8000, 24'h000000, 24'h010000, 24'h7F0000,
              24'h3F8000, 24'h3F0001, 24'h5F0001, 24'h1F0000, 24'h1E0000};
    te    = '{27'h0402000, 27'h0C02000, 27'h1000000, 27'h2000000, 27'h47FFFFF,
              RNE ? 27'h03F8002 : 27'h03F8001,
              RNE ? 27'h0400000 : 27'h03FFFFF,
              RNE ? 27'h47FFFFF : 27'h07FFFFF,
              27'h0000000, 27'h2000000};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; a = ta[i]; b = tb_op[i];
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL dir_in_ready row=%0d got=%b want=1", i, in_ready);
      end
      @(posedge clk); #1 in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (out_valid === 1'b1) begin
          lat = k;
          break;
        end
      end
      checks++;
      if (lat != 3) begin
        failures++; $display("FAIL dir_latency row=%0d got=%0d want=3", i, lat);
      end
      checks++;
      if ({flags, prod} !== te[i]) begin
        failures++;
        $display("FAIL dir_result row=%0d got=%h want=%h", i, {flags, prod}, te[i]);
      end
    end
  endtask

  // Continuous stream with out_ready held high: one result per cycle
  task automatic test_throughput();
    logic [26:0] want;
    bit want_v;
    exp_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      @(posedge clk); #1;
      if (c < 16) begin
        a = rand_op(); b = rand_op(); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 16) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++; $display("FAIL tput_in_ready cycle=%0d got=%b want=1", c, in_ready);
        end
        exp_q.push_back(model(a, b));
      end
      want_v = (c >= 3) && (c < 19);
      checks++;
      if (out_valid !== want_v) begin
        failures++; $display("FAIL tput_out_valid cycle=%0d got=%b want=%b", c, out_valid, want_v);
      end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        checks++;
        if ({flags, prod} !== want) begin
          failures++; $display("FAIL tput_result cycle=%0d got=%h want=%h", c, {flags, prod}, want);
        end
      end
    end
  endtask

  // Random valid/ready stream checked through the expected queue
  task automatic test_random();
    int n, sent, got, cyc;
    bit pending, stalled;
    logic [26:0] held, want;
    n = 300; sent = 0; got = 0; cyc = 0; pending = 0; stalled = 0; held = '0;
    exp_q.delete();
    while ((got < n) && (cyc < 5000)) begin
      @(posedge clk); #1;
      if (!pending) begin
        if (sent < n && $urandom_range(0, 3) != 0) begin
          a = rand_op(); b = rand_op(); in_valid = 1'b1; pending = 1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        failures++; $display("FAIL rnd_in_ready cycle=%0d got=%b want=%b", cyc, in_ready, !out_valid || out_ready);
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || {flags, prod} !== held) begin
          failures++; $display("FAIL rnd_stall_hold cycle=%0d got=%b/%h want=1/%h", cyc, out_valid, {flags, prod}, held);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b)); sent++; pending = 0;
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_extra_result cycle=%0d got=%h want=none", cyc, {flags, prod});
        end else begin
          want = exp_q.pop_front();
          if ({flags, prod} !== want) begin
            failures++; $display("FAIL rnd_result idx=%0d got=%h want=%h", got, {flags, prod}, want);
          end
        end
        got++;
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      held = {flags, prod};
      cyc++;
    end
    checks++;
    if (got != n) begin
      failures++; $display("FAIL rnd_count got=%0d want=%0d", got, n);
    end
  endtask

  // Eight back-to-back products, out_ready cycling 1,0,0
  task automatic test_back_to_back();
    int n, sent, got, cyc;
    bit pending, stalled;
    logic [26:0] held, want;
    n = 8; sent = 0; got = 0; cyc = 0; pending = 0; stalled = 0; held = '0;
    exp_q.delete();
    while ((got < n) && (cyc < 200)) begin
      @(posedge clk); #1;
      if (!pending) begin
        if (sent < n) begin
          a = rand_op(); b = rand_op(); in_valid = 1'b1; pending = 1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ((cyc % 3) == 0);
      @(negedge clk);
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        failures++; $display("FAIL b2b_in_ready cycle=%0d got=%b want=%b", cyc, in_ready, !out_valid || out_ready);
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || {flags, prod} !== held) begin
          failures++; $display("FAIL b2b_stall_hold cycle=%0d got=%b/%h want=1/%h", cyc, out_valid, {flags, prod}, held);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b)); sent++; pending = 0;
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_extra_result cycle=%0d got=%h want=none", cyc, {flags, prod});
        end else begin
          want = exp_q.pop_front();
          if ({flags, prod} !== want) begin
            failures++; $display("FAIL b2b_result idx=%0d got=%h want=%h", got, {flags, prod}, want);
          end
        end
        got++;
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      held = {flags, prod};
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != n) begin
      failures++; $display("FAIL b2b_count got=%0d want=%0d", got, n);
    end
    // pipe should now be empty: nothing duplicated afterwards
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL b2b_dup_result got=%b want=0", out_valid);
      end
    end
  endtask

  // Reset with two products in flight, then a fresh product
  task automatic test_reset_in_flight();
    logic [26:0] want;
    int lat;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = rand_op(); b = rand_op();
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL rif_accept idx=%0d got=%b want=1", i, in_ready);
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL rif_fill got=%b want=1", out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rif_async_clear got=%b want=0", out_valid);
    end
    checks++;
    if ({flags, prod} !== 27'h0) begin
      failures++; $display("FAIL rif_prod_clear got=%h want=0", {flags, prod});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL rif_in_ready got=%b want=1", in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL rif_stale cycle=%0d got=%b want=0", c, out_valid);
      end
    end
    @(posedge clk); #1;
    a = 24'h3F8000; b = 24'hC0C000; in_valid = 1'b1;
    want = model(a, b);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL rif_next_accept got=%b want=1", in_ready);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 3) begin
      failures++; $display("FAIL rif_next_latency got=%0d want=3", lat);
    end
    checks++;
    if ({flags, prod} !== want) begin
      failures++; $display("FAIL rif_next_result got=%h want=%h", {flags, prod}, want);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_throughput();
    test_random();
    test_back_to_back();
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
